mips_cpu_mem_arbiter: RTL and testbench
=======================================

Name: mips_cpu_mem_arbiter

Overview:
- Shares the CPU's single Avalon-MM memory master port between two requesters: instruction fetch (I) and data load/store (D).
- Sits between the CPU control/datapath and the external memory interface.
- Serialises accesses, holds each command stable while waitrequest is high, and returns read data plus a one-cycle acknowledge to the winning requester.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width; byteenable width is DATA_W/8.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_req  in  1  fetch request; held high until i_ack
- i_addr  in  ADDR_W  fetch byte address
- i_rdata  out  DATA_W  fetched word, valid while i_ack=1
- i_ack  out  1  one-cycle completion pulse
- d_req  in  1  data request; held high until d_ack
- d_write  in  1  1=write, 0=read
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  store/load byte enables
- d_rdata  out  DATA_W  load data, valid while d_ack=1
- d_ack  out  1  one-cycle completion pulse
- avm_address  out  ADDR_W  word-aligned address; bits[1:0] forced to 0
- avm_read  out  1  Avalon read strobe
- avm_write  out  1  Avalon write strobe
- avm_writedata  out  DATA_W  Avalon write data
- avm_byteenable  out  DATA_W/8  Avalon byte enables; 4'b1111 for fetches
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  DATA_W  valid in the cycle avm_read=1 and avm_waitrequest=0

Behaviour:
- All outputs are registered.
- Reset values: avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, avm_byteenable=0, i_ack=0, d_ack=0, i_rdata=0, d_rdata=0; state=IDLE.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - Eligible requester = req high AND its own ack not high this cycle. This prevents re-issue in the cycle the requester sees its ack.
  - If any requester is eligible, pick the winner, latch its command into the avm_* registers, and go to BUSY_I or BUSY_D.
  - avm_read/avm_write go high on the next cycle.
- BUSY_x:
  - While avm_waitrequest=1, all avm_* outputs are held unchanged.
  - When avm_waitrequest=0: deassert avm_read/avm_write at the next edge; for reads, capture avm_readdata into x_rdata; pulse x_ack for exactly one cycle; return to IDLE.
- Latency: req seen at edge N -> strobe high from N+1 -> with zero wait states, ack high at N+2. Each wait-state cycle adds one cycle.
- Fixed priority (default): D beats I when both are eligible.
- Only one transaction is outstanding at a time. avm_read and avm_write are never both high.
- A request arriving during BUSY is not sampled until IDLE.
- Changing a requester's inputs while its req is pending and unacked is illegal; the latched command is used regardless.
- Reset asserted mid-transaction: state returns to IDLE at that edge, and strobes and acks are cleared there; the in-flight request is dropped with no ack.
- x_rdata holds its last captured value until the next read completes for that requester.
- Writes leave d_rdata unchanged.

Optional Feature:
- Macro: MIPS_CPU_ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last-grant register (reset value = I) gives priority to the requester not granted last when both are eligible. A single eligible requester always wins.
- Undefined: fixed priority D over I, with no last-grant register.

Test Plan:
- Fetch, zero waits: i_req=1, i_addr=0xBFC00000, readdata=0x3C011234 -> avm_read=1, avm_address=0xBFC00000, byteenable=4'hF one cycle later; i_ack=1 and i_rdata=0x3C011234 two cycles after req.
- Store with 3 wait states: d_write=1, d_addr=0x00001006, d_wdata=0xDEADBEEF, d_be=4'b1100 -> avm_address=0x00001004; avm_write held 4 cycles with stable data/be; single d_ack pulse; avm_read stays 0 throughout.
- Simultaneous i_req and d_req (fixed priority) -> D served first, then I. There is no gap beyond one IDLE cycle, and no duplicate D access after d_ack. With the macro defined and the last grant = D, I is served first.
- Back-to-back: requester holds req through ack then drops it -> exactly one avm transaction per request; a new d_req 1 cycle after d_ack starts a second transaction.
- Reset mid-transaction: reset asserted during the 2nd wait-state cycle of a fetch -> after that edge, avm_read=0, i_ack=0, state IDLE; no ack ever issued for the dropped fetch.
- Load readdata capture: d_req read from 0x10 returning 0x000000FF after 2 waits -> d_rdata=0x000000FF with d_ack; d_rdata is unchanged through a following write.

Source files
------------

// File: rtl/mips_cpu_mem_arbiter_if.sv
// Requester-side and Avalon-MM-side signals of the I/D memory arbiter.
// The slave modport is the arbiter's view; master is the CPU/memory environment.
interface mips_cpu_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic [DATA_W-1:0]     i_rdata;
  logic                  i_ack;
  logic                  d_req;
  logic                  d_write;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_be;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_ack;
  logic [ADDR_W-1:0]     avm_address;
  logic                  avm_read;
  logic                  avm_write;
  logic [DATA_W-1:0]     avm_writedata;
  logic [DATA_W/8-1:0]   avm_byteenable;
  logic                  avm_waitrequest;
  logic [DATA_W-1:0]     avm_readdata;

  modport slave (
    input  i_req, i_addr, d_req, d_write, d_addr, d_wdata, d_be,
           avm_waitrequest, avm_readdata,
    output i_rdata, i_ack, d_rdata, d_ack,
           avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
  );

  modport master (
    output i_req, i_addr, d_req, d_write, d_addr, d_wdata, d_be,
           avm_waitrequest, avm_readdata,
    input  i_rdata, i_ack, d_rdata, d_ack,
           avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
  );
endinterface

// File: rtl/mips_cpu_mem_arbiter.sv
// Shares one Avalon-MM master between instruction fetch and data access.
// MIPS_CPU_ARB_ROUND_ROBIN_EN: alternate priority on contention (default: D over I).
module mips_cpu_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_cpu_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  state_t state;

  logic i_elig, d_elig, grant_d;

  // A requester still sees its ack this cycle; ignoring it avoids a re-issue.
  assign i_elig = bus.i_req & ~bus.i_ack;
  assign d_elig = bus.d_req & ~bus.d_ack;

`ifdef MIPS_CPU_ARB_ROUND_ROBIN_EN
  logic last_d;
  assign grant_d = d_elig & (~i_elig | ~last_d);
`else
  assign grant_d = d_elig;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      bus.avm_read       <= 1'b0;
      bus.avm_write      <= 1'b0;
      bus.avm_address    <= '0;
      bus.avm_writedata  <= '0;
      bus.avm_byteenable <= '0;
      bus.i_ack          <= 1'b0;
      bus.d_ack          <= 1'b0;
      bus.i_rdata        <= '0;
      bus.d_rdata        <= '0;
`ifdef MIPS_CPU_ARB_ROUND_ROBIN_EN
      last_d             <= 1'b0;
`endif
    end else begin
      bus.i_ack <= 1'b0;
      bus.d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            bus.avm_address    <= {bus.d_addr[ADDR_W-1:2], 2'b00};
            bus.avm_read       <= ~bus.d_write;
            bus.avm_write      <= bus.d_write;
            bus.avm_writedata  <= bus.d_wdata;
            bus.avm_byteenable <= bus.d_be;
            state              <= BUSY_D;
`ifdef MIPS_CPU_ARB_ROUND_ROBIN_EN
            last_d             <= 1'b1;
`endif
          end else if (i_elig) begin
            bus.avm_address    <= {bus.i_addr[ADDR_W-1:2], 2'b00};
            bus.avm_read       <= 1'b1;
            bus.avm_write      <= 1'b0;
            bus.avm_byteenable <= '1;
            state              <= BUSY_I;
`ifdef MIPS_CPU_ARB_ROUND_ROBIN_EN
            last_d             <= 1'b0;
`endif
          end
        end
        BUSY_I: begin
          if (!bus.avm_waitrequest) begin
            bus.avm_read <= 1'b0;
            bus.i_rdata  <= bus.avm_readdata;
            bus.i_ack    <= 1'b1;
            state        <= IDLE;
          end
        end
        BUSY_D: begin
          if (!bus.avm_waitrequest) begin
            if (bus.avm_read) bus.d_rdata <= bus.avm_readdata;
            bus.avm_read  <= 1'b0;
            bus.avm_write <= 1'b0;
            bus.d_ack     <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Scoreboard bench for mips_cpu_mem_arbiter: directed requests, queued expectations,
// a responder modelling Avalon wait states and a monitor checking bus and acks.
module tb_mips_cpu_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_cpu_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mips_cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        chk_wd;
  } avm_exp_t;

  typedef struct {
    int          waits;
    logic [31:0] rdata;
  } resp_t;

  avm_exp_t    exp_avm[$];
  resp_t       resp_q[$];
  logic [31:0] exp_i_q[$];
  logic [31:0] exp_d_q[$];
  logic [31:0] d_model = '0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic void push_txn(input bit is_d, input bit wr, input logic [31:0] exp_addr,
                                   input logic [31:0] wdata, input logic [3:0] be,
                                   input int waits, input logic [31:0] rdata, input bit acked);
    avm_exp_t e;
    resp_t    r;
    e.rd = !wr; e.wr = wr; e.addr = exp_addr; e.wdata = wdata; e.be = be; e.chk_wd = wr;
    exp_avm.push_back(e);
    r.waits = waits; r.rdata = rdata;
    resp_q.push_back(r);
    if (acked) begin
      if (is_d) begin
        if (!wr) d_model = rdata;
        exp_d_q.push_back(d_model);
      end else begin
        exp_i_q.push_back(rdata);
      end
    end
  endfunction

  // Slave model: wait states per transaction; readdata is wrong until the data phase.
  initial begin
    int          cnt;
    logic [31:0] rd;
    logic        s, sprev;
    resp_t       r;
    cnt = 0; rd = '0; sprev = 1'b0;
    bus.avm_waitrequest = 1'b1;
    bus.avm_readdata    = 32'hA5A5A5A5;
    forever begin
      @(negedge clk);
      s = (bus.avm_read === 1'b1) || (bus.avm_write === 1'b1);
      if (s && !sprev) begin
        if (resp_q.size() > 0) begin
          r = resp_q.pop_front(); cnt = r.waits; rd = r.rdata;
        end else begin
          cnt = 0; rd = '0;
        end
      end
      if (s) begin
        bus.avm_waitrequest = (cnt != 0);
        bus.avm_readdata    = (cnt != 0) ? ~rd : rd;
        if (cnt != 0) cnt--;
      end else begin
        bus.avm_waitrequest = 1'b1;
        bus.avm_readdata    = 32'hA5A5A5A5;
      end
      sprev = s;
    end
  end

  // Monitor: every new strobe is matched to the next expected transaction, held
  // strobes must stay unchanged, and every ack pops its expected read data.
  initial begin
    logic     s, sprev;
    avm_exp_t cur;
    avm_exp_t e;
    logic     have;
    sprev = 1'b0; have = 1'b0;
    cur.rd = 0; cur.wr = 0; cur.addr = 0; cur.wdata = 0; cur.be = 0; cur.chk_wd = 0;
    forever begin
      @(negedge clk);
      s = (bus.avm_read === 1'b1) || (bus.avm_write === 1'b1);
      if (!reset) begin
        if (bus.avm_read && bus.avm_write) begin
          checks++; errors++;
          $display("FAIL strobe_excl: read and write both high");
        end
        if (s && !sprev) begin
          checks++;
          if (exp_avm.size() == 0) begin
            errors++; have = 1'b0;
            $display("FAIL avm_unexpected: r=%0d w=%0d addr=%h", bus.avm_read, bus.avm_write, bus.avm_address);
          end else begin
            e = exp_avm.pop_front(); cur = e; have = 1'b1;
            if (bus.avm_read !== e.rd || bus.avm_write !== e.wr || bus.avm_address !== e.addr ||
                bus.avm_byteenable !== e.be || (e.chk_wd && bus.avm_writedata !== e.wdata)) begin
              errors++;
              $display("FAIL avm_txn: got r=%0d w=%0d addr=%h wd=%h be=%h expected r=%0d w=%0d addr=%h wd=%h be=%h",
                       bus.avm_read, bus.avm_write, bus.avm_address, bus.avm_writedata, bus.avm_byteenable,
                       e.rd, e.wr, e.addr, e.wdata, e.be);
            end
          end
        end else if (s && have) begin
          checks++;
          if (bus.avm_read !== cur.rd || bus.avm_write !== cur.wr || bus.avm_address !== cur.addr ||
              bus.avm_byteenable !== cur.be || (cur.chk_wd && bus.avm_writedata !== cur.wdata)) begin
            errors++;
            $display("FAIL avm_hold: got r=%0d w=%0d addr=%h wd=%h be=%h expected held addr=%h wd=%h be=%h",
                     bus.avm_read, bus.avm_write, bus.avm_address, bus.avm_writedata, bus.avm_byteenable,
                     cur.addr, cur.wdata, cur.be);
          end
        end
        if (bus.i_ack === 1'b1) begin
          checks++;
          if (exp_i_q.size() == 0) begin
            errors++; $display("FAIL i_ack_unexpected: got i_ack=1 expected 0");
          end else begin
            e.addr = exp_i_q.pop_front();
            if (bus.i_rdata !== e.addr) begin
              errors++; $display("FAIL i_rdata: got %h expected %h", bus.i_rdata, e.addr);
            end
          end
        end
        if (bus.d_ack === 1'b1) begin
          checks++;
          if (exp_d_q.size() == 0) begin
            errors++; $display("FAIL d_ack_unexpected: got d_ack=1 expected 0");
          end else begin
            e.addr = exp_d_q.pop_front();
            if (bus.d_rdata !== e.addr) begin
              errors++; $display("FAIL d_rdata: got %h expected %h", bus.d_rdata, e.addr);
            end
          end
        end
      end
      sprev = s;
    end
  end

  // Requesters: hold req through the ack cycle, drop it one cycle later.
  task automatic req_i(input logic [31:0] addr, output int lat);
    int n;
    bus.i_addr = addr; bus.i_req = 1'b1; n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus.i_ack && n < 60);
    if (!bus.i_ack) begin
      checks++; errors++; $display("FAIL i_timeout: got no i_ack expected ack within 60 cycles");
    end
    lat = n;
    @(posedge clk); #1;
    bus.i_req = 1'b0;
  endtask

  task automatic req_d(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output int lat);
    int n;
    bus.d_write = wr; bus.d_addr = addr; bus.d_wdata = wdata; bus.d_be = be;
    bus.d_req = 1'b1; n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus.d_ack && n < 60);
    if (!bus.d_ack) begin
      checks++; errors++; $display("FAIL d_timeout: got no d_ack expected ack within 60 cycles");
    end
    lat = n;
    @(posedge clk); #1;
    bus.d_req = 1'b0;
  endtask

  initial begin
    int lat, lat2, n;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_avm_read", {31'b0, bus.avm_read}, 32'h0);
    chk("rst_avm_write", {31'b0, bus.avm_write}, 32'h0);
    chk("rst_avm_address", bus.avm_address, 32'h0);
    chk("rst_avm_writedata", bus.avm_writedata, 32'h0);
    chk("rst_avm_byteenable", {28'b0, bus.avm_byteenable}, 32'h0);
    chk("rst_i_ack", {31'b0, bus.i_ack}, 32'h0);
    chk("rst_d_ack", {31'b0, bus.d_ack}, 32'h0);
    chk("rst_i_rdata", bus.i_rdata, 32'h0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Fetch, zero waits: ack two cycles after req.
    push_txn(0, 0, 32'hBFC00000, 32'h0, 4'hF, 0, 32'h3C011234, 1);
    req_i(32'hBFC00000, lat);
    chk("lat_fetch", lat, 2);

    // Unaligned store, three wait states: strobe held four cycles.
    push_txn(1, 1, 32'h00001004, 32'hDEADBEEF, 4'b1100, 3, 32'h0, 1);
    req_d(1'b1, 32'h00001006, 32'hDEADBEEF, 4'b1100, lat);
    chk("lat_store", lat, 5);

    // Simultaneous requests; previous grant was D.
`ifdef MIPS_CPU_ARB_ROUND_ROBIN_EN
    push_txn(0, 0, 32'h00400004, 32'h0, 4'hF, 0, 32'h33334444, 1);
    push_txn(1, 0, 32'h00002000, 32'h0, 4'hF, 1, 32'h11112222, 1);
`else
    push_txn(1, 0, 32'h00002000, 32'h0, 4'hF, 1, 32'h11112222, 1);
    push_txn(0, 0, 32'h00400004, 32'h0, 4'hF, 0, 32'h33334444, 1);
`endif
    fork
      req_d(1'b0, 32'h00002000, 32'h0, 4'hF, lat);
      req_i(32'h00400004, lat2);
    join
`ifdef MIPS_CPU_ARB_ROUND_ROBIN_EN
    chk("sim_i_first", {31'b0, lat2 < lat}, 32'h1);
`else
    chk("sim_d_first", {31'b0, lat < lat2}, 32'h1);
`endif

    // Back-to-back data requests.
    push_txn(1, 0, 32'h00003008, 32'h0, 4'hF, 0, 32'h55556666, 1);
    push_txn(1, 1, 32'h0000300C, 32'h77778888, 4'b0011, 1, 32'h0, 1);
    req_d(1'b0, 32'h00003008, 32'h0, 4'hF, lat);
    req_d(1'b1, 32'h0000300C, 32'h77778888, 4'b0011, lat);
    chk("lat_b2b_second", lat, 3);

    // Reset during the second wait-state cycle of a fetch: dropped, never acked.
    push_txn(0, 0, 32'h00400000, 32'h0, 4'hF, 5, 32'h99999999, 0);
    bus.i_addr = 32'h00400000; bus.i_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; bus.i_req = 1'b0;
    @(posedge clk); #1;
    chk("midrst_avm_read", {31'b0, bus.avm_read}, 32'h0);
    chk("midrst_i_ack", {31'b0, bus.i_ack}, 32'h0);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Load with two waits, then a store that must not disturb d_rdata.
    push_txn(1, 0, 32'h00000010, 32'h0, 4'hF, 2, 32'h000000FF, 1);
    req_d(1'b0, 32'h00000010, 32'h0, 4'hF, lat);
    chk("lat_load", lat, 4);
    push_txn(1, 1, 32'h00000014, 32'hCAFEF00D, 4'hF, 0, 32'h0, 1);
    req_d(1'b1, 32'h00000014, 32'hCAFEF00D, 4'hF, lat);
    chk("d_rdata_after_write", bus.d_rdata, 32'h000000FF);

    // Recovery fetch after the earlier reset.
    push_txn(0, 0, 32'hBFC00004, 32'h0, 4'hF, 0, 32'h24020001, 1);
    req_i(32'hBFC00007, lat);
    chk("lat_fetch2", lat, 2);

    n = 0;
    while ((exp_avm.size() + exp_i_q.size() + exp_d_q.size()) != 0 && n < 50) begin
      @(posedge clk); n++;
    end
    repeat (5) @(posedge clk);
    #1;
    chk("avm_q_drained", exp_avm.size(), 0);
    chk("i_q_drained", exp_i_q.size(), 0);
    chk("d_q_drained", exp_d_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
